// File: rtl/br_enc_gray_pkg.sv
// Shared types and level-split helpers for the Gray/binary converter.
// Exports: br_enc_gray_mode_e, stage_level_lo(), stage_levels().
package br_enc_gray_pkg;

   typedef enum logic {
      GrayToBin = 1'b0,
      BinToGray = 1'b1
   } br_enc_gray_mode_e;

   // First prefix-XOR level handled by stage s.
   // Stages take ceil(L/N) levels each; trailing stages
   // clamp to L and may end up with zero levels.
   function automatic int stage_level_lo(
      input int width,
      input int num_stages,
      input int s
   );
      int l;
      int per;
      int lo;
      l   = $clog2(width);
      per = (l + num_stages - 1) / num_stages;
      lo  = s * per;
      return (lo > l) ? l : lo;
   endfunction

   function automatic int stage_levels(
      input int width,
      input int num_stages,
      input int s
   );
      return stage_level_lo(width, num_stages, s + 1)
           - stage_level_lo(width, num_stages, s);
   endfunction

endpackage

// File: rtl/br_enc_gray_conv_stage.sv
// One register stage: prefix-XOR levels [LevelLo, LevelHi) plus handshake.
// Ports: clk, rst_n, in_* (upstream valid/ready), out_* (downstream).
module br_enc_gray_conv_stage
   import br_enc_gray_pkg::*;
#(
   parameter int Width   = 8,
   parameter int LevelLo = 0,
   parameter int LevelHi = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_mode_i,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_mode_o,
   output logic [Width-1:0] out_data_o
);

   localparam int NumLevels = $clog2(Width);

   logic             valid_q, valid_d;
   logic             mode_q, mode_d;
   logic [Width-1:0] data_q, data_d;
   logic [Width-1:0] conv;
   logic             load;

   // Level k folds in the value 2^k bits above.
   // Level 0 alone is also the binary-to-Gray step.
   always_comb begin
      conv = in_data_i;
      for (int k = 0; k < NumLevels; k++) begin
         if (k >= LevelLo && k < LevelHi &&
             (in_mode_i == GrayToBin || k == 0)) begin
            conv = conv ^ (conv >> (1 << k));
         end
      end
   end

   assign in_ready_o = !valid_q || out_ready_i;
   assign load       = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      mode_d  = mode_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         mode_d  = in_mode_i;
         data_d  = conv;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         mode_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_mode_o  = mode_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/br_enc_gray_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready flow.
// Ports: clk, rst_n, push_* (input transaction), pop_* (converted result).
module br_enc_gray_conv_pipe
   import br_enc_gray_pkg::*;
#(
   parameter int Width     = 8,
   parameter int NumStages = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic             push_mode,
   input  logic [Width-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic             pop_mode,
   output logic [Width-1:0] pop_data
);

   if (Width < 2 || Width > 256) begin : g_bad_width
      $error("Width must be in 2..256");
   end
   if (NumStages < 1 || NumStages > $clog2(Width)) begin : g_bad_stages
      $error("NumStages must be in 1..clog2(Width)");
   end

   // Index s is the input of stage s; index NumStages is the output.
   logic             vld  [NumStages+1];
   logic             rdy  [NumStages+1];
   logic             mode [NumStages+1];
   logic [Width-1:0] data [NumStages+1];

   assign vld[0]         = push_valid;
   assign mode[0]        = push_mode;
   assign data[0]        = push_data;
   assign push_ready     = rdy[0];
   assign rdy[NumStages] = pop_ready;

   for (genvar s = 0; s < NumStages; s++) begin : g_stage
      localparam int Lo = stage_level_lo(Width, NumStages, s);
      localparam int Hi = Lo + stage_levels(Width, NumStages, s);

      br_enc_gray_conv_stage #(
         .Width  (Width),
         .LevelLo(Lo),
         .LevelHi(Hi)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid_i (vld[s]),
         .in_ready_o (rdy[s]),
         .in_mode_i  (mode[s]),
         .in_data_i  (data[s]),
         .out_valid_o(vld[s+1]),
         .out_ready_i(rdy[s+1]),
         .out_mode_o (mode[s+1]),
         .out_data_o (data[s+1])
      );
   end

   assign pop_valid = vld[NumStages];
   assign pop_mode  = mode[NumStages];
   assign pop_data  = data[NumStages];

   a_pop_hold : assert property (
      @(posedge clk) disable iff (!rst_n)
      pop_valid && !pop_ready |=>
         pop_valid && $stable(pop_data) && $stable(pop_mode)
   );

endmodule

// File: tb/tb_br_enc_gray_conv_pipe.sv
// Directed and scoreboard bench for br_enc_gray_conv_pipe.
// Covers five width/stage configurations sharing clk and rst_n.
module tb_br_enc_gray_conv_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] g2b(
      input logic [63:0] g,
      input int          w
   );
      logic [63:0] b;
      b = '0;
      b[w-1] = g[w-1];
      for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // A: Width 8, 1 stage
   logic a_pv = 0, a_pr, a_pm = 0, a_ov, a_or = 0, a_om;
   logic [7:0] a_pd = '0, a_od;
   // B: Width 8, 3 stages
   logic b_pv = 0, b_pr, b_pm = 0, b_ov, b_or = 0, b_om;
   logic [7:0] b_pd = '0, b_od;
   // C: Width 16, 4 stages
   logic c_pv = 0, c_pr, c_pm = 0, c_ov, c_or = 0, c_om;
   logic [15:0] c_pd = '0, c_od;
   // D: Width 64, 3 stages
   logic d_pv = 0, d_pr, d_pm = 0, d_ov, d_or = 0, d_om;
   logic [63:0] d_pd = '0, d_od;
   // E: Width 2, 1 stage
   logic e_pv = 0, e_pr, e_pm = 0, e_ov, e_or = 0, e_om;
   logic [1:0] e_pd = '0, e_od;

   br_enc_gray_conv_pipe #(.Width(8), .NumStages(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .push_valid(a_pv), .push_ready(a_pr),
      .push_mode(a_pm), .push_data(a_pd),
      .pop_valid(a_ov), .pop_ready(a_or),
      .pop_mode(a_om), .pop_data(a_od));

   br_enc_gray_conv_pipe #(.Width(8), .NumStages(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .push_valid(b_pv), .push_ready(b_pr),
      .push_mode(b_pm), .push_data(b_pd),
      .pop_valid(b_ov), .pop_ready(b_or),
      .pop_mode(b_om), .pop_data(b_od));

   br_enc_gray_conv_pipe #(.Width(16), .NumStages(4)) u_c (
      .clk(clk), .rst_n(rst_n),
      .push_valid(c_pv), .push_ready(c_pr),
      .push_mode(c_pm), .push_data(c_pd),
      .pop_valid(c_ov), .pop_ready(c_or),
      .pop_mode(c_om), .pop_data(c_od));

   br_enc_gray_conv_pipe #(.Width(64), .NumStages(3)) u_d (
      .clk(clk), .rst_n(rst_n),
      .push_valid(d_pv), .push_ready(d_pr),
      .push_mode(d_pm), .push_data(d_pd),
      .pop_valid(d_ov), .pop_ready(d_or),
      .pop_mode(d_om), .pop_data(d_od));

   br_enc_gray_conv_pipe #(.Width(2), .NumStages(1)) u_e (
      .clk(clk), .rst_n(rst_n),
      .push_valid(e_pv), .push_ready(e_pr),
      .push_mode(e_pm), .push_data(e_pd),
      .pop_valid(e_ov), .pop_ready(e_or),
      .pop_mode(e_om), .pop_data(e_od));

   logic [15:0] c_in [5] = '{16'h0001, 16'hFFFF, 16'h8000,
                             16'h00FF, 16'h1234};
   logic        c_md [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [15:0] c_ex [5] = '{16'h0001, 16'hAAAA, 16'hFFFF,
                             16'h0080, 16'h1B2E};
   logic [1:0]  e_in [8] = '{2'b00, 2'b01, 2'b11, 2'b10,
                             2'b00, 2'b01, 2'b10, 2'b11};
   logic [1:0]  e_ex [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                             2'b00, 2'b01, 2'b11, 2'b10};

   logic [63:0] sb_data [$];
   logic        sb_mode [$];
   logic [63:0] x;
   int          idx;
   int          cyc;
   int          total;

   initial begin
      // ---- reset values
      #1 rst_n = 1'b0;
      #1;
      chk("rst_pop_valid", 64'(a_ov), 64'd0);
      chk("rst_pop_data", 64'(a_od), 64'd0);
      chk("rst_pop_mode", 64'(a_om), 64'd0);
      chk("rst_c_valid", 64'(c_ov), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_push_ready", 64'(a_pr), 64'd1);

      // ---- A: gray->bin, 1-cycle latency
      @(negedge clk);
      a_or = 1; a_pv = 1; a_pm = 0; a_pd = 8'h80;
      @(negedge clk);
      chk("a_valid0", 64'(a_ov), 64'd1);
      chk("a_80", 64'(a_od), 64'hFF);
      a_pd = 8'h0C;
      @(negedge clk);
      chk("a_0c", 64'(a_od), 64'h08);
      chk("a_mode", 64'(a_om), 64'd0);
      a_pv = 0;
      @(negedge clk);
      chk("a_empty", 64'(a_ov), 64'd0);

      // ---- B: mixed modes, 3-cycle latency
      b_or = 1; b_pv = 1; b_pm = 1; b_pd = 8'hFF;
      @(negedge clk);
      chk("b_early1", 64'(b_ov), 64'd0);
      b_pm = 0; b_pd = 8'h80;
      @(negedge clk);
      chk("b_early2", 64'(b_ov), 64'd0);
      b_pv = 0;
      @(negedge clk);
      chk("b_valid1", 64'(b_ov), 64'd1);
      chk("b_ff_b2g", 64'(b_od), 64'h80);
      chk("b_mode1", 64'(b_om), 64'd1);
      @(negedge clk);
      chk("b_valid2", 64'(b_ov), 64'd1);
      chk("b_80_g2b", 64'(b_od), 64'hFF);
      chk("b_mode2", 64'(b_om), 64'd0);
      @(negedge clk);
      chk("b_empty", 64'(b_ov), 64'd0);

      // ---- C: fill under stall, hold, drain in order
      c_or = 0;
      for (int i = 0; i < 5; i++) begin
         c_pv = 1; c_pm = c_md[i]; c_pd = c_in[i];
         @(negedge clk);
      end
      for (int j = 0; j < 10; j++) begin
         chk("c_stall_ready", 64'(c_pr), 64'd0);
         chk("c_stall_valid", 64'(c_ov), 64'd1);
         chk("c_stall_data", 64'(c_od), 64'(c_ex[0]));
         if (j < 9) @(negedge clk);
      end
      c_or = 1;
      #1 chk("c_ready_comb", 64'(c_pr), 64'd1);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         c_pv = 0;
         chk("c_drain_valid", 64'(c_ov), 64'd1);
         chk("c_drain_data", 64'(c_od), 64'(c_ex[i]));
         chk("c_drain_mode", 64'(c_om), 64'(c_md[i]));
      end
      @(negedge clk);
      chk("c_drained", 64'(c_ov), 64'd0);

      // ---- E: Width 2 exhaustive, both modes
      e_or = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("e_valid", 64'(e_ov), 64'd1);
            chk("e_data", 64'(e_od), 64'(e_ex[i-1]));
         end
         if (i < 8) begin
            e_pv = 1; e_pm = (i >= 4); e_pd = e_in[i];
         end else begin
            e_pv = 0;
         end
      end

      // ---- D: stream with random pop_ready, round trip
      total = 4096;
      idx = 0;
      cyc = 0;
      while ((idx < total || sb_data.size() > 0 || d_ov)
             && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         d_or = 1'($urandom_range(0, 1));
         if (idx < total) begin
            if ((idx >> 1) == 0) x = 64'h8000_0000_0000_0000;
            else x = {48'h0, 16'((idx >> 1) * 40503)};
            d_pv = 1;
            d_pm = idx[0];
            d_pd = idx[0] ? g2b(x, 64) : x;
         end else begin
            d_pv = 0;
         end
         #1;
         if (d_ov && d_or) begin
            if (sb_data.size() == 0) begin
               chk("d_extra", 64'd1, 64'd0);
            end else begin
               chk("d_data", d_od, sb_data.pop_front());
               chk("d_mode", 64'(d_om), 64'(sb_mode.pop_front()));
            end
         end
         if (d_pv && d_pr) begin
            sb_data.push_back(idx[0] ? x : g2b(x, 64));
            sb_mode.push_back(idx[0]);
            idx++;
         end
      end
      d_pv = 0;
      chk("d_pushed", 64'(idx), 64'(total));
      chk("d_left", 64'(sb_data.size()), 64'd0);

      // ---- reset with 3 stages of C occupied
      @(negedge clk);
      c_or = 0;
      for (int i = 0; i < 3; i++) begin
         c_pv = 1; c_pm = 0; c_pd = c_in[i];
         @(negedge clk);
      end
      c_pv = 0;
      chk("c_pre_rst", 64'(c_ov), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("c_rst_valid", 64'(c_ov), 64'd0);
      chk("c_rst_data", 64'(c_od), 64'd0);
      chk("c_rst_mode", 64'(c_om), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      c_or = 1; c_pv = 1; c_pm = 1; c_pd = 16'h0003;
      #1 chk("c_post_ready", 64'(c_pr), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         c_pv = 0;
         chk("c_post_early", 64'(c_ov), 64'd0);
      end
      @(negedge clk);
      chk("c_post_valid", 64'(c_ov), 64'd1);
      chk("c_post_data", 64'(c_od), 64'h0002);
      chk("c_post_mode", 64'(c_om), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
